// File: rtl/rob_multiport.sv
// Multi-port reorder buffer: count-based occupancy, N writeback ports, self-squash on mispredict.
// Define ROB_DUAL_COMMIT_EN to allow a second in-order REG commit per cycle.
module rob_multiport #(
  parameter int ROB_DEPTH_WIDTH = 3,
  parameter int XLEN            = 32,
  parameter int WB_PORTS        = 2,
  parameter int RD_WIDTH        = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rdy,
  input  logic                          flush,
  input  logic                          alloc_valid,
  input  logic [1:0]                    alloc_kind,
  input  logic [1:0]                    alloc_sub,
  input  logic [RD_WIDTH-1:0]           alloc_rd,
  input  logic [XLEN-1:0]               alloc_pc,
  input  logic [XLEN-1:0]               alloc_val,
  input  logic [XLEN-1:0]               alloc_addr,
  input  logic                          alloc_ready,
  input  logic                          alloc_pred,
  output logic [ROB_DEPTH_WIDTH-1:0]    alloc_id,
  output logic                          rob_full,
  output logic                          rob_empty,
  input  logic [WB_PORTS-1:0]           wb_valid,
  input  logic [WB_PORTS*ROB_DEPTH_WIDTH-1:0] wb_id,
  input  logic [WB_PORTS*XLEN-1:0]      wb_val,
  input  logic [WB_PORTS*XLEN-1:0]      wb_addr,
  input  logic [ROB_DEPTH_WIDTH-1:0]    q1_id,
  input  logic [ROB_DEPTH_WIDTH-1:0]    q2_id,
  output logic                          q1_ready,
  output logic                          q2_ready,
  output logic [XLEN-1:0]               q1_val,
  output logic [XLEN-1:0]               q2_val,
  input  logic                          mem_busy,
  output logic [1:0]                    rob_rf_en,
  output logic [RD_WIDTH-1:0]           rob_rf_rd0,
  output logic [RD_WIDTH-1:0]           rob_rf_rd1,
  output logic [XLEN-1:0]               rob_rf_val0,
  output logic [XLEN-1:0]               rob_rf_val1,
  output logic                          rob_mem_en,
  output logic [1:0]                    rob_mem_sub,
  output logic [XLEN-1:0]               rob_mem_addr,
  output logic [XLEN-1:0]               rob_mem_val,
  output logic                          rob_bp_en,
  output logic [XLEN-1:0]               rob_bp_pc,
  output logic                          rob_bp_taken,
  output logic                          rob_bp_correct,
  output logic                          rob_flush,
  output logic [XLEN-1:0]               rob_correct_pc
);

  localparam int DEPTH = 1 << ROB_DEPTH_WIDTH;
  localparam int W     = ROB_DEPTH_WIDTH;
  localparam int CW    = ROB_DEPTH_WIDTH + 1;

  localparam logic [1:0] K_REG    = 2'd0;
  localparam logic [1:0] K_STORE  = 2'd1;
  localparam logic [1:0] K_BRANCH = 2'd2;
  localparam logic [1:0] K_JALR   = 2'd3;

  logic [1:0]          kind_q  [DEPTH];
  logic [1:0]          kind_d  [DEPTH];
  logic [1:0]          sub_q   [DEPTH];
  logic [1:0]          sub_d   [DEPTH];
  logic [RD_WIDTH-1:0] rd_q    [DEPTH];
  logic [RD_WIDTH-1:0] rd_d    [DEPTH];
  logic [XLEN-1:0]     pc_q    [DEPTH];
  logic [XLEN-1:0]     pc_d    [DEPTH];
  logic [XLEN-1:0]     val_q   [DEPTH];
  logic [XLEN-1:0]     val_d   [DEPTH];
  logic [XLEN-1:0]     addr_q  [DEPTH];
  logic [XLEN-1:0]     addr_d  [DEPTH];
  logic                ready_q [DEPTH];
  logic                ready_d [DEPTH];
  logic                pred_q  [DEPTH];
  logic                pred_d  [DEPTH];
  logic                taken_q [DEPTH];
  logic                taken_d [DEPTH];

  logic [W-1:0]  head_q, head_d, tail_q, tail_d, h1;
  logic [CW-1:0] count_q, count_d, n_commit;

  logic [1:0]          rf_en_q, rf_en_d;
  logic [RD_WIDTH-1:0] rf_rd0_q, rf_rd0_d, rf_rd1_q, rf_rd1_d;
  logic [XLEN-1:0]     rf_val0_q, rf_val0_d, rf_val1_q, rf_val1_d;
  logic                mem_en_q, mem_en_d;
  logic [1:0]          mem_sub_q, mem_sub_d;
  logic [XLEN-1:0]     mem_addr_q, mem_addr_d, mem_val_q, mem_val_d;
  logic                bp_en_q, bp_en_d, bp_taken_q, bp_taken_d, bp_correct_q, bp_correct_d;
  logic [XLEN-1:0]     bp_pc_q, bp_pc_d;
  logic                rflush_q, rflush_d;
  logic [XLEN-1:0]     correct_pc_q, correct_pc_d;

  logic commit0, commit1, mispredict, accept;

  function automatic logic occupied(input logic [W-1:0] id, input logic [W-1:0] head,
                                    input logic [CW-1:0] cnt);
    logic [W-1:0] off;
    off = id - head;
    return {1'b0, off} < cnt;
  endfunction

  assign h1        = head_q + W'(1);
  assign rob_full  = (count_q == CW'(DEPTH));
  assign rob_empty = (count_q == '0);
  assign alloc_id  = tail_q;
  assign accept    = alloc_valid && !rob_full;

  assign q1_ready = ready_q[q1_id];
  assign q1_val   = val_q[q1_id];
  assign q2_ready = ready_q[q2_id];
  assign q2_val   = val_q[q2_id];

  assign commit0    = (count_q != '0) && ready_q[head_q] && (kind_q[head_q] != K_STORE || !mem_busy);
  assign mispredict = commit0 && (kind_q[head_q] == K_JALR ||
                      (kind_q[head_q] == K_BRANCH && pred_q[head_q] != taken_q[head_q]));
`ifdef ROB_DUAL_COMMIT_EN
  assign commit1 = commit0 && kind_q[head_q] == K_REG && count_q >= CW'(2) &&
                   ready_q[h1] && kind_q[h1] == K_REG;
`else
  assign commit1 = 1'b0;
`endif
  assign n_commit = CW'(commit0) + CW'(commit1);

  always_comb begin : comb_next
    logic [W-1:0] wid;
    kind_d  = kind_q;
    sub_d   = sub_q;
    rd_d    = rd_q;
    pc_d    = pc_q;
    val_d   = val_q;
    addr_d  = addr_q;
    ready_d = ready_q;
    pred_d  = pred_q;
    taken_d = taken_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    wid     = '0;

    rf_en_d      = '0;
    rf_rd0_d     = rf_rd0_q;
    rf_rd1_d     = rf_rd1_q;
    rf_val0_d    = rf_val0_q;
    rf_val1_d    = rf_val1_q;
    mem_en_d     = 1'b0;
    mem_sub_d    = mem_sub_q;
    mem_addr_d   = mem_addr_q;
    mem_val_d    = mem_val_q;
    bp_en_d      = 1'b0;
    bp_pc_d      = bp_pc_q;
    bp_taken_d   = bp_taken_q;
    bp_correct_d = bp_correct_q;
    rflush_d     = 1'b0;
    correct_pc_d = correct_pc_q;

    if (flush) begin
      tail_d  = head_q;
      count_d = '0;
    end else begin
      // Later ports overwrite earlier ones, so the highest index wins on equal ids.
      for (int p = 0; p < WB_PORTS; p++) begin
        wid = wb_id[p*W +: W];
        if (wb_valid[p] && occupied(wid, head_q, count_q)) begin
          ready_d[wid] = 1'b1;
          unique case (kind_q[wid])
            K_REG:    val_d[wid]   = wb_val[p*XLEN +: XLEN];
            K_JALR:   addr_d[wid]  = wb_val[p*XLEN +: XLEN];
            K_STORE: begin
              addr_d[wid] = wb_addr[p*XLEN +: XLEN];
              val_d[wid]  = wb_val[p*XLEN +: XLEN];
            end
            K_BRANCH: taken_d[wid] = wb_val[p*XLEN];
          endcase
        end
      end

      if (commit0) begin
        unique case (kind_q[head_q])
          K_REG, K_JALR: begin
            rf_en_d[0] = 1'b1;
            rf_rd0_d   = rd_q[head_q];
            rf_val0_d  = val_q[head_q];
          end
          K_STORE: begin
            mem_en_d   = 1'b1;
            mem_sub_d  = sub_q[head_q];
            mem_addr_d = addr_q[head_q];
            mem_val_d  = val_q[head_q];
          end
          K_BRANCH: begin
            bp_en_d      = 1'b1;
            bp_pc_d      = pc_q[head_q];
            bp_taken_d   = taken_q[head_q];
            bp_correct_d = (pred_q[head_q] == taken_q[head_q]);
          end
        endcase
      end
      if (commit1) begin
        rf_en_d[1] = 1'b1;
        rf_rd1_d   = rd_q[h1];
        rf_val1_d  = val_q[h1];
      end
      if (mispredict) begin
        rflush_d     = 1'b1;
        correct_pc_d = (kind_q[head_q] == K_JALR || taken_q[head_q]) ? addr_q[head_q] : val_q[head_q];
      end

      head_d = head_q + W'(commit0) + W'(commit1);

      // A mispredict squashes everything younger, including this cycle's allocation.
      if (mispredict) begin
        tail_d  = h1;
        count_d = '0;
      end else begin
        if (accept) begin
          kind_d[tail_q]  = alloc_kind;
          sub_d[tail_q]   = alloc_sub;
          rd_d[tail_q]    = alloc_rd;
          pc_d[tail_q]    = alloc_pc;
          val_d[tail_q]   = alloc_val;
          addr_d[tail_q]  = alloc_addr;
          ready_d[tail_q] = alloc_ready;
          pred_d[tail_q]  = alloc_pred;
          taken_d[tail_q] = 1'b0;
          tail_d          = tail_q + W'(1);
        end
        count_d = count_q + CW'(accept) - n_commit;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        kind_q[i]  <= '0;
        sub_q[i]   <= '0;
        rd_q[i]    <= '0;
        pc_q[i]    <= '0;
        val_q[i]   <= '0;
        addr_q[i]  <= '0;
        ready_q[i] <= 1'b0;
        pred_q[i]  <= 1'b0;
        taken_q[i] <= 1'b0;
      end
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      rf_en_q      <= '0;
      rf_rd0_q     <= '0;
      rf_rd1_q     <= '0;
      rf_val0_q    <= '0;
      rf_val1_q    <= '0;
      mem_en_q     <= 1'b0;
      mem_sub_q    <= '0;
      mem_addr_q   <= '0;
      mem_val_q    <= '0;
      bp_en_q      <= 1'b0;
      bp_pc_q      <= '0;
      bp_taken_q   <= 1'b0;
      bp_correct_q <= 1'b0;
      rflush_q     <= 1'b0;
      correct_pc_q <= '0;
    end else if (rdy || flush) begin
      kind_q       <= kind_d;
      sub_q        <= sub_d;
      rd_q         <= rd_d;
      pc_q         <= pc_d;
      val_q        <= val_d;
      addr_q       <= addr_d;
      ready_q      <= ready_d;
      pred_q       <= pred_d;
      taken_q      <= taken_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      rf_en_q      <= rf_en_d;
      rf_rd0_q     <= rf_rd0_d;
      rf_rd1_q     <= rf_rd1_d;
      rf_val0_q    <= rf_val0_d;
      rf_val1_q    <= rf_val1_d;
      mem_en_q     <= mem_en_d;
      mem_sub_q    <= mem_sub_d;
      mem_addr_q   <= mem_addr_d;
      mem_val_q    <= mem_val_d;
      bp_en_q      <= bp_en_d;
      bp_pc_q      <= bp_pc_d;
      bp_taken_q   <= bp_taken_d;
      bp_correct_q <= bp_correct_d;
      rflush_q     <= rflush_d;
      correct_pc_q <= correct_pc_d;
    end
  end

  assign rob_rf_en      = rf_en_q;
  assign rob_rf_rd0     = rf_rd0_q;
  assign rob_rf_rd1     = rf_rd1_q;
  assign rob_rf_val0    = rf_val0_q;
  assign rob_rf_val1    = rf_val1_q;
  assign rob_mem_en     = mem_en_q;
  assign rob_mem_sub    = mem_sub_q;
  assign rob_mem_addr   = mem_addr_q;
  assign rob_mem_val    = mem_val_q;
  assign rob_bp_en      = bp_en_q;
  assign rob_bp_pc      = bp_pc_q;
  assign rob_bp_taken   = bp_taken_q;
  assign rob_bp_correct = bp_correct_q;
  assign rob_flush      = rflush_q;
  assign rob_correct_pc = correct_pc_q;

endmodule

// File: tb/tb_rob_multiport.sv
// Directed bench for rob_multiport: commit streams are scoreboarded, control outputs checked inline.
module tb_rob_multiport;
  localparam int W  = 3;
  localparam int XL = 32;
  localparam int NP = 2;
  localparam int RW = 5;

  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1, flush = 1'b0;
  logic alloc_valid = 1'b0;
  logic [1:0] alloc_kind = '0, alloc_sub = '0;
  logic [RW-1:0] alloc_rd = '0;
  logic [XL-1:0] alloc_pc = '0, alloc_val = '0, alloc_addr = '0;
  logic alloc_ready = 1'b0, alloc_pred = 1'b0;
  logic [W-1:0] alloc_id;
  logic rob_full, rob_empty;
  logic [NP-1:0] wb_valid = '0;
  logic [NP*W-1:0] wb_id = '0;
  logic [NP*XL-1:0] wb_val = '0, wb_addr = '0;
  logic [W-1:0] q1_id = '0, q2_id = '0;
  logic q1_ready, q2_ready;
  logic [XL-1:0] q1_val, q2_val;
  logic mem_busy = 1'b0;
  logic [1:0] rob_rf_en;
  logic [RW-1:0] rob_rf_rd0, rob_rf_rd1;
  logic [XL-1:0] rob_rf_val0, rob_rf_val1;
  logic rob_mem_en;
  logic [1:0] rob_mem_sub;
  logic [XL-1:0] rob_mem_addr, rob_mem_val;
  logic rob_bp_en, rob_bp_taken, rob_bp_correct, rob_flush;
  logic [XL-1:0] rob_bp_pc, rob_correct_pc;

  rob_multiport #(.ROB_DEPTH_WIDTH(W), .XLEN(XL), .WB_PORTS(NP), .RD_WIDTH(RW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_kind(alloc_kind), .alloc_sub(alloc_sub),
    .alloc_rd(alloc_rd), .alloc_pc(alloc_pc), .alloc_val(alloc_val), .alloc_addr(alloc_addr),
    .alloc_ready(alloc_ready), .alloc_pred(alloc_pred), .alloc_id(alloc_id),
    .rob_full(rob_full), .rob_empty(rob_empty),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_val(wb_val), .wb_addr(wb_addr),
    .q1_id(q1_id), .q2_id(q2_id), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_val(q1_val), .q2_val(q2_val), .mem_busy(mem_busy),
    .rob_rf_en(rob_rf_en), .rob_rf_rd0(rob_rf_rd0), .rob_rf_rd1(rob_rf_rd1),
    .rob_rf_val0(rob_rf_val0), .rob_rf_val1(rob_rf_val1),
    .rob_mem_en(rob_mem_en), .rob_mem_sub(rob_mem_sub),
    .rob_mem_addr(rob_mem_addr), .rob_mem_val(rob_mem_val),
    .rob_bp_en(rob_bp_en), .rob_bp_pc(rob_bp_pc), .rob_bp_taken(rob_bp_taken),
    .rob_bp_correct(rob_bp_correct), .rob_flush(rob_flush), .rob_correct_pc(rob_correct_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [RW-1:0] rd; logic [XL-1:0] val; } rf_t;
  typedef struct packed { logic [1:0] sub; logic [XL-1:0] addr; logic [XL-1:0] val; } mem_t;
  typedef struct packed { logic [XL-1:0] pc; logic taken; logic correct; } bp_t;

  rf_t  rf_q[$];
  mem_t mem_q[$];
  bp_t  bp_q[$];
  rf_t  e_rf;
  mem_t e_mem;
  bp_t  e_bp;

  int vectors = 0;
  int miscompares = 0;

`ifdef ROB_DUAL_COMMIT_EN
  localparam int       DRAIN_CYC = 4;
  localparam logic [1:0] DRAIN_EN = 2'b11;
`else
  localparam int       DRAIN_CYC = 8;
  localparam logic [1:0] DRAIN_EN = 2'b01;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [1:0] kind, input logic [1:0] sub, input logic [RW-1:0] rd,
                       input logic [XL-1:0] pc, input logic [XL-1:0] val, input logic [XL-1:0] addr,
                       input logic rdy_in, input logic pred);
    alloc_valid = 1'b1; alloc_kind = kind; alloc_sub = sub; alloc_rd = rd;
    alloc_pc = pc; alloc_val = val; alloc_addr = addr; alloc_ready = rdy_in; alloc_pred = pred;
    tick();
    alloc_valid = 1'b0;
  endtask

  // Commit monitor: every enable must match the oldest expected commit of its kind.
  always @(negedge clk) begin
    if (!rst) begin
      if (rob_rf_en[0]) begin
        if (rf_q.size() == 0) chk("rf0_unexpected", 64'(rob_rf_en), 64'd0);
        else begin
          e_rf = rf_q.pop_front();
          chk("rf0_rd", 64'(rob_rf_rd0), 64'(e_rf.rd));
          chk("rf0_val", 64'(rob_rf_val0), 64'(e_rf.val));
        end
      end
      if (rob_rf_en[1]) begin
        if (!rob_rf_en[0]) chk("rf1_without_rf0", 64'(rob_rf_en), 64'd3);
        if (rf_q.size() == 0) chk("rf1_unexpected", 64'(rob_rf_en), 64'd0);
        else begin
          e_rf = rf_q.pop_front();
          chk("rf1_rd", 64'(rob_rf_rd1), 64'(e_rf.rd));
          chk("rf1_val", 64'(rob_rf_val1), 64'(e_rf.val));
        end
      end
      if (rob_mem_en) begin
        if (mem_q.size() == 0) chk("mem_unexpected", 64'(rob_mem_en), 64'd0);
        else begin
          e_mem = mem_q.pop_front();
          chk("mem_sub", 64'(rob_mem_sub), 64'(e_mem.sub));
          chk("mem_addr", 64'(rob_mem_addr), 64'(e_mem.addr));
          chk("mem_val", 64'(rob_mem_val), 64'(e_mem.val));
        end
      end
      if (rob_bp_en) begin
        if (bp_q.size() == 0) chk("bp_unexpected", 64'(rob_bp_en), 64'd0);
        else begin
          e_bp = bp_q.pop_front();
          chk("bp_pc", 64'(rob_bp_pc), 64'(e_bp.pc));
          chk("bp_taken", 64'(rob_bp_taken), 64'(e_bp.taken));
          chk("bp_correct", 64'(rob_bp_correct), 64'(e_bp.correct));
        end
      end
    end
  end

  initial begin
    int n;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_empty", 64'(rob_empty), 64'd1);
    chk("reset_full", 64'(rob_full), 64'd0);
    chk("reset_alloc_id", 64'(alloc_id), 64'd0);
    chk("reset_rf_en", 64'(rob_rf_en), 64'd0);
    chk("reset_flush", 64'(rob_flush), 64'd0);

    // Fill: head entry waits on writeback so the buffer can reach full.
    rf_q.push_back('{rd: 5'd1, val: 32'h500});
    alloc(2'd0, 2'd0, 5'd1, 32'h0, 32'h100, 32'h0, 1'b0, 1'b0);
    for (int i = 1; i < 8; i++) begin
      rf_q.push_back('{rd: RW'(i + 1), val: 32'h100 + XL'(i)});
      alloc(2'd0, 2'd0, RW'(i + 1), 32'h0, 32'h100 + XL'(i), 32'h0, 1'b1, 1'b0);
    end
    chk("fill_full", 64'(rob_full), 64'd1);
    chk("fill_alloc_id", 64'(alloc_id), 64'd0);
    alloc(2'd0, 2'd0, 5'd31, 32'h0, 32'hdead, 32'h0, 1'b1, 1'b0);
    chk("ninth_full", 64'(rob_full), 64'd1);
    chk("ninth_alloc_id", 64'(alloc_id), 64'd0);
    wb_valid = 2'b01; wb_id = {3'd0, 3'd0}; wb_val = {32'd0, 32'h500};
    tick();
    wb_valid = '0;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (rob_rf_en != 2'b00) begin
        n++;
        chk("drain_rf_en", 64'(rob_rf_en), 64'(DRAIN_EN));
      end
    end
    chk("drain_cycles", 64'(n), 64'(DRAIN_CYC));
    chk("drain_empty", 64'(rob_empty), 64'd1);

    // Mispredicted branch squashes the younger REG entries.
    alloc(2'd2, 2'd0, 5'd0, 32'h10, 32'h14, 32'h100, 1'b0, 1'b1);
    alloc(2'd0, 2'd0, 5'd5, 32'h0, 32'h55, 32'h0, 1'b1, 1'b0);
    alloc(2'd0, 2'd0, 5'd6, 32'h0, 32'h66, 32'h0, 1'b1, 1'b0);
    alloc(2'd0, 2'd0, 5'd7, 32'h0, 32'h77, 32'h0, 1'b1, 1'b0);
    bp_q.push_back('{pc: 32'h10, taken: 1'b0, correct: 1'b0});
    wb_valid = 2'b10; wb_id = {3'd0, 3'd0}; wb_val = {32'd0, 32'd0};
    tick();
    wb_valid = '0;
    tick();
    chk("bp_flush", 64'(rob_flush), 64'd1);
    chk("bp_correct_pc", 64'(rob_correct_pc), 64'h14);
    chk("bp_en", 64'(rob_bp_en), 64'd1);
    chk("bp_empty", 64'(rob_empty), 64'd1);
    chk("bp_no_rf", 64'(rob_rf_en), 64'd0);
    tick();
    chk("bp_flush_pulse", 64'(rob_flush), 64'd0);
    chk("bp_squashed_rf", 64'(rob_rf_en), 64'd0);

    // Store held back by mem_busy.
    mem_busy = 1'b1;
    alloc(2'd1, 2'd2, 5'd0, 32'h20, 32'h0, 32'h0, 1'b0, 1'b0);
    mem_q.push_back('{sub: 2'd2, addr: 32'h30000, val: 32'h41});
    wb_valid = 2'b01; wb_id = {3'd0, 3'd1}; wb_val = {32'd0, 32'h41}; wb_addr = {32'd0, 32'h30000};
    tick();
    wb_valid = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("store_busy_hold", 64'(rob_mem_en), 64'd0);
    end
    mem_busy = 1'b0;
    tick();
    chk("store_commit", 64'(rob_mem_en), 64'd1);
    tick();
    chk("store_pulse", 64'(rob_mem_en), 64'd0);
    chk("store_empty", 64'(rob_empty), 64'd1);

    // Same id on both ports, then a writeback to an unoccupied id.
    alloc(2'd0, 2'd0, 5'd10, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    alloc(2'd0, 2'd0, 5'd11, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    rf_q.push_back('{rd: 5'd10, val: 32'd9});
    rf_q.push_back('{rd: 5'd11, val: 32'h33});
    q1_id = 3'd2; q2_id = 3'd5;
    wb_valid = 2'b11; wb_id = {3'd2, 3'd2}; wb_val = {32'd9, 32'd5};
    tick();
    chk("dup_q1_ready", 64'(q1_ready), 64'd1);
    chk("dup_q1_val", 64'(q1_val), 64'd9);
    wb_valid = 2'b01; wb_id = {3'd0, 3'd5}; wb_val = {32'd0, 32'h77};
    tick();
    chk("unocc_q2_val", 64'(q2_val), 64'h105);
    chk("unocc_q2_ready", 64'(q2_ready), 64'd1);
    wb_valid = 2'b01; wb_id = {3'd0, 3'd3}; wb_val = {32'd0, 32'h33};
    tick();
    wb_valid = '0;
    tick(); tick();
    chk("dup_empty", 64'(rob_empty), 64'd1);

    // Asynchronous reset with five entries in flight.
    for (int i = 0; i < 5; i++)
      alloc(2'd0, 2'd0, RW'(20 + i), 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("pre_rst_empty", 64'(rob_empty), 64'd0);
    chk("pre_rst_alloc_id", 64'(alloc_id), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_empty", 64'(rob_empty), 64'd1);
    chk("rst_alloc_id", 64'(alloc_id), 64'd0);
    chk("rst_rf_val0", 64'(rob_rf_val0), 64'd0);
    chk("rst_mem_addr", 64'(rob_mem_addr), 64'd0);
    chk("rst_correct_pc", 64'(rob_correct_pc), 64'd0);
    chk("rst_bp_pc", 64'(rob_bp_pc), 64'd0);
    chk("rst_q1_ready", 64'(q1_ready), 64'd0);
    chk("rst_q1_val", 64'(q1_val), 64'd0);
    #2;
    rst = 1'b0;

    // External flush overrides concurrent allocation and writeback.
    alloc(2'd0, 2'd0, 5'd3, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    alloc(2'd0, 2'd0, 5'd4, 32'h0, 32'h44, 32'h0, 1'b1, 1'b0);
    q1_id = 3'd0;
    flush = 1'b1;
    alloc_valid = 1'b1; alloc_kind = 2'd0; alloc_rd = 5'd7; alloc_val = 32'h7; alloc_ready = 1'b1;
    wb_valid = 2'b01; wb_id = {3'd0, 3'd0}; wb_val = {32'd0, 32'h99};
    tick();
    flush = 1'b0; alloc_valid = 1'b0; wb_valid = '0;
    chk("flush_empty", 64'(rob_empty), 64'd1);
    chk("flush_alloc_id", 64'(alloc_id), 64'd0);
    chk("flush_wb_ignored", 64'(q1_ready), 64'd0);
    tick();
    chk("flush_no_rf", 64'(rob_rf_en), 64'd0);
    tick();
    chk("flush_no_rf2", 64'(rob_rf_en), 64'd0);

    rf_q.push_back('{rd: 5'd9, val: 32'h999});
    alloc(2'd0, 2'd0, 5'd9, 32'h0, 32'h999, 32'h0, 1'b1, 1'b0);
    tick(); tick(); tick();
    chk("rf_q_drained", 64'(rf_q.size()), 64'd0);
    chk("mem_q_drained", 64'(mem_q.size()), 64'd0);
    chk("bp_q_drained", 64'(bp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
